// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline memory port between I-cache and D-cache misses; grant is registered (1 cycle), response is forwarded combinationally.
// Backpressure: the loser simply waits in IDLE; ties alternate by last grant, and the just-served cache is masked for one IDLE cycle.
module cache_mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  i_wait_cnt,
  output logic [31:0]  d_wait_cnt
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;   // 1 when the most recent grant went to D
  logic          mask_i_q, mask_i_d;
  logic          mask_d_q, mask_d_d;
  logic [31:0]   addr_q, addr_d;
  logic [255:0]  wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [31:0]   i_wait_cnt_q, i_wait_cnt_d;
  logic [31:0]   d_wait_cnt_q, d_wait_cnt_d;
  logic          ireq, dreq, d_any;

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    mask_i_d     = mask_i_q;
    mask_d_d     = mask_d_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    i_wait_cnt_d = i_wait_cnt_q;
    d_wait_cnt_d = d_wait_cnt_q;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;

    d_any = d_read | d_write;
    ireq  = i_read & ~mask_i_q;
    dreq  = d_any & ~mask_d_q;

    case (state_q)
      IDLE: begin
        // Masks only ever live for a single IDLE cycle.
        mask_i_d = 1'b0;
        mask_d_d = 1'b0;
        if (dreq && (!ireq || !last_d_q)) begin
          state_d  = SERVE_D;
          addr_d   = d_address;
          wdata_d  = d_wdata;
          wr_d     = d_write;
          last_d_d = 1'b1;
        end else if (ireq) begin
          state_d  = SERVE_I;
          addr_d   = i_address;
          wdata_d  = d_wdata;
          wr_d     = d_write;
          last_d_d = 1'b0;
        end
      end
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q;
        if (pmem_resp) begin
          i_resp   = 1'b1;
          i_rdata  = pmem_rdata;
          state_d  = IDLE;
          mask_i_d = 1'b1;
        end
      end
      SERVE_D: begin
        pmem_write   = wr_q;
        pmem_read    = ~wr_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        if (pmem_resp) begin
          d_resp   = 1'b1;
          d_rdata  = pmem_rdata;
          state_d  = IDLE;
          mask_d_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_read && (state_q != SERVE_I) && (i_wait_cnt_q != 32'hFFFF_FFFF))
      i_wait_cnt_d = i_wait_cnt_q + 32'd1;
    if (d_any && (state_q != SERVE_D) && (d_wait_cnt_q != 32'hFFFF_FFFF))
      d_wait_cnt_d = d_wait_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_d_q     <= 1'b0;
      mask_i_q     <= 1'b0;
      mask_d_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      i_wait_cnt_q <= '0;
      d_wait_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      last_d_q     <= last_d_d;
      mask_i_q     <= mask_i_d;
      mask_d_q     <= mask_d_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      i_wait_cnt_q <= i_wait_cnt_d;
      d_wait_cnt_q <= d_wait_cnt_d;
    end
  end

  assign i_wait_cnt = i_wait_cnt_q;
  assign d_wait_cnt = d_wait_cnt_q;

endmodule
